// File: rtl/store_merge_unit.sv
// Store merge unit: sw writes directly; sh/sb read-modify-write against word memory. Optional macro STORE_LANE_SEL_EN selects lanes by addr[1:0].
// Latency: sw done at cycle 2, sh/sb done at cycle 3+MEM_LAT; start is ignored while busy, with no queueing.
module store_merge_unit #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  ctrl_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_rd_o,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_wr_o,
  output logic [31:0] mem_wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   wdata_q;
  logic [1:0]    ctrl_q;
  logic [31:0]   mem_addr_q;
  logic          mem_rd_q;
  logic          mem_wr_q;
  logic [31:0]   mem_wdata_q;
  logic          busy_q;
  logic          done_q;

  logic          is_word;
  logic          misalign;
  logic [31:0]   word_addr;
  logic [31:0]   merged_d;

  assign is_word = (ctrl_i == 2'b00) || (ctrl_i == 2'b11);

`ifdef STORE_LANE_SEL_EN
  logic [1:0] lane_q;
  logic       err_q;

  assign word_addr = {addr_i[31:2], 2'b00};
  assign misalign  = (ctrl_i == 2'b01 && addr_i[0]) || (is_word && addr_i[1:0] != 2'b00);
  assign err_o     = err_q;

  // Little-endian lanes: the register's low byte/half lands on the addressed lane.
  always_comb begin
    merged_d = mem_rdata_i;
    if (ctrl_q == 2'b10) begin
      merged_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged_d[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end
`else
  assign word_addr = addr_i;
  assign misalign  = 1'b0;
  assign err_o     = 1'b0;

  always_comb begin
    merged_d = mem_rdata_i;
    if (ctrl_q == 2'b10) begin
      merged_d[7:0] = wdata_q[7:0];
    end else begin
      merged_d[15:0] = wdata_q[15:0];
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wdata_q     <= '0;
      ctrl_q      <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef STORE_LANE_SEL_EN
      lane_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle: default low, raised only on the entering edge.
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef STORE_LANE_SEL_EN
      err_q    <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            wdata_q <= wdata_i;
            ctrl_q  <= ctrl_i;
            busy_q  <= 1'b1;
`ifdef STORE_LANE_SEL_EN
            lane_q  <= addr_i[1:0];
`endif
            if (misalign) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
`ifdef STORE_LANE_SEL_EN
              err_q   <= 1'b1;
`endif
            end else if (is_word) begin
              state_q     <= S_WRITE;
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= word_addr;
              mem_wdata_q <= wdata_i;
            end else begin
              state_q    <= S_READ;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= word_addr;
              cnt_q      <= '0;
            end
          end
        end
        S_READ: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == LAST) begin
            mem_wdata_q <= merged_d;
            mem_wr_q    <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_WRITE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WRITE: begin
          state_q     <= S_DONE;
          done_q      <= 1'b1;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench: two instances (MEM_LAT=1 and MEM_LAT=3) share stimulus; status = {rd, wr, busy, done, err}.
module tb_store_merge_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  ctrl = '0;

  logic [31:0] a1, wd1, a3, wd3;
  logic        rd1, wr1, b1, dn1, e1;
  logic        rd3, wr3, b3, dn3, e3;
  logic [4:0]  st1, st3;

  int errors = 0;
  int checks = 0;

  assign st1 = {rd1, wr1, b1, dn1, e1};
  assign st3 = {rd3, wr3, b3, dn3, e3};

  always #5 clk = ~clk;

  store_merge_unit #(.MEM_LAT(1)) u1 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .addr_i(addr), .wdata_i(wdata), .ctrl_i(ctrl),
    .mem_addr_o(a1), .mem_rd_o(rd1), .mem_rdata_i(rdata), .mem_wr_o(wr1), .mem_wdata_o(wd1),
    .busy_o(b1), .done_o(dn1), .err_o(e1)
  );

  store_merge_unit #(.MEM_LAT(3)) u3 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .addr_i(addr), .wdata_i(wdata), .ctrl_i(ctrl),
    .mem_addr_o(a3), .mem_rd_o(rd3), .mem_rdata_i(rdata), .mem_wr_o(wr3), .mem_wdata_o(wd3),
    .busy_o(b3), .done_o(dn3), .err_o(e3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; returns in cycle 1.
  task automatic issue(input logic [31:0] a, input logic [31:0] w, input logic [1:0] c);
    addr  = a;
    wdata = w;
    ctrl  = c;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({st1, a1, wd1} !== '0) begin
      errors++;
      $display("FAIL reset_d1 got st=%b addr=%h wdata=%h want all 0", st1, a1, wd1);
    end
    checks++;
    if ({st3, a3, wd3} !== '0) begin
      errors++;
      $display("FAIL reset_d3 got st=%b addr=%h wdata=%h want all 0", st3, a3, wd3);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_sw();
    issue(32'h40, 32'hDEADBEEF, 2'b00);
    checks++;
    if (st1 !== 5'b01100 || a1 !== 32'h40 || wd1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_c1 got st=%b addr=%h wdata=%h want 01100 00000040 deadbeef", st1, a1, wd1);
    end
    checks++;
    if (st3 !== 5'b01100 || wd3 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_c1_lat3 got st=%b wdata=%h want 01100 deadbeef", st3, wd3);
    end
    step();
    checks++;
    if (st1 !== 5'b00110) begin
      errors++;
      $display("FAIL sw_done got st=%b want 00110", st1);
    end
    step();
    checks++;
    if (st1 !== 5'b00000 || a1 !== 32'h0) begin
      errors++;
      $display("FAIL sw_idle got st=%b addr=%h want 00000 0", st1, a1);
    end
  endtask

  task automatic test_back_to_back();
    issue(32'h44, 32'h12345678, 2'b11);
    checks++;
    if (st1 !== 5'b01100 || a1 !== 32'h44 || wd1 !== 32'h12345678) begin
      errors++;
      $display("FAIL b2b_wr got st=%b addr=%h wdata=%h want 01100 00000044 12345678", st1, a1, wd1);
    end
    step();
    checks++;
    if (st1 !== 5'b00110) begin
      errors++;
      $display("FAIL b2b_done got st=%b want 00110", st1);
    end
    step();
  endtask

  task automatic test_sh_lat1();
    rdata = 32'hDEADDEAD;
    issue(32'h100, 32'hAAAABBCC, 2'b01);
    checks++;
    if (st1 !== 5'b10100 || a1 !== 32'h100) begin
      errors++;
      $display("FAIL sh_rd got st=%b addr=%h want 10100 00000100", st1, a1);
    end
    step();
    checks++;
    if (st1 !== 5'b00100) begin
      errors++;
      $display("FAIL sh_wait got st=%b want 00100", st1);
    end
    rdata = 32'h11223344;
    step();
    rdata = 32'hDEADDEAD;
    checks++;
    if (st1 !== 5'b01100 || wd1 !== 32'h1122BBCC || a1 !== 32'h100) begin
      errors++;
      $display("FAIL sh_wr got st=%b wdata=%h addr=%h want 01100 1122bbcc 00000100", st1, wd1, a1);
    end
    step();
    checks++;
    if (st1 !== 5'b00110) begin
      errors++;
      $display("FAIL sh_done got st=%b want 00110", st1);
    end
    step();
    checks++;
    if (st1 !== 5'b00000) begin
      errors++;
      $display("FAIL sh_idle got st=%b want 00000", st1);
    end
    step();
    step();
  endtask

  task automatic test_sb_lat3();
    rdata = 32'hDEADDEAD;
    issue(32'h80, 32'h000000EE, 2'b10);
    checks++;
    if (st3 !== 5'b10100 || a3 !== 32'h80) begin
      errors++;
      $display("FAIL sb3_rd got st=%b addr=%h want 10100 00000080", st3, a3);
    end
    for (int k = 2; k <= 4; k++) begin
      step();
      checks++;
      if (st3 !== 5'b00100) begin
        errors++;
        $display("FAIL sb3_wait%0d got st=%b want 00100", k, st3);
      end
      if (k == 4) rdata = 32'h11223344;
    end
    step();
    rdata = 32'hDEADDEAD;
    checks++;
    if (st3 !== 5'b01100 || wd3 !== 32'h112233EE || a3 !== 32'h80) begin
      errors++;
      $display("FAIL sb3_wr got st=%b wdata=%h addr=%h want 01100 112233ee 00000080", st3, wd3, a3);
    end
    step();
    checks++;
    if (st3 !== 5'b00110) begin
      errors++;
      $display("FAIL sb3_done got st=%b want 00110", st3);
    end
    step();
    checks++;
    if (st3 !== 5'b00000) begin
      errors++;
      $display("FAIL sb3_idle got st=%b want 00000", st3);
    end
  endtask

  task automatic test_start_in_wait();
    int nwr1 = 0, ndn1 = 0, nwr3 = 0, ndn3 = 0;
    logic [31:0] w1 = '0, w3 = '0;
    rdata = 32'h11223344;
    issue(32'h80, 32'h000000EE, 2'b10);
    for (int c = 1; c <= 9; c++) begin
      if (wr1) begin nwr1++; w1 = wd1; end
      if (dn1) ndn1++;
      if (wr3) begin nwr3++; w3 = wd3; end
      if (dn3) ndn3++;
      start = (c == 1 || c == 2);
      addr  = 32'h200;
      wdata = 32'h55555555;
      ctrl  = 2'b00;
      step();
    end
    start = 1'b0;
    checks++;
    if (nwr1 != 1 || ndn1 != 1 || w1 !== 32'h112233EE) begin
      errors++;
      $display("FAIL busy_start_d1 got wr=%0d done=%0d wdata=%h want 1 1 112233ee", nwr1, ndn1, w1);
    end
    checks++;
    if (nwr3 != 1 || ndn3 != 1 || w3 !== 32'h112233EE) begin
      errors++;
      $display("FAIL busy_start_d3 got wr=%0d done=%0d wdata=%h want 1 1 112233ee", nwr3, ndn3, w3);
    end
    checks++;
    if (b1 !== 1'b0 || b3 !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_idle got busy1=%b busy3=%b want 0 0", b1, b3);
    end
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    rdata = 32'h11223344;
    issue(32'h80, 32'h000000EE, 2'b10);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({st3, a3, wd3, st1, a1, wd1} !== '0) begin
      errors++;
      $display("FAIL rst_mid got st3=%b a3=%h st1=%b a1=%h want all 0", st3, a3, st1, a1);
    end
    for (int c = 0; c < 6; c++) begin
      strobes += int'(rd1) + int'(wr1) + int'(dn1) + int'(rd3) + int'(wr3) + int'(dn3);
      step();
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL rst_mid_strobes got %0d strobes want 0", strobes);
    end
    issue(32'h40, 32'hDEADBEEF, 2'b00);
    checks++;
    if (st3 !== 5'b01100 || wd3 !== 32'hDEADBEEF || a3 !== 32'h40) begin
      errors++;
      $display("FAIL rst_sw_wr got st=%b wdata=%h addr=%h want 01100 deadbeef 00000040", st3, wd3, a3);
    end
    step();
    checks++;
    if (st3 !== 5'b00110) begin
      errors++;
      $display("FAIL rst_sw_done got st=%b want 00110", st3);
    end
    step();
  endtask

  task automatic test_lane();
    rdata = 32'h11223344;
`ifdef STORE_LANE_SEL_EN
    issue(32'h43, 32'h000000EE, 2'b10);
    checks++;
    if (st1 !== 5'b10100 || a1 !== 32'h40) begin
      errors++;
      $display("FAIL lane_sb_rd got st=%b addr=%h want 10100 00000040", st1, a1);
    end
    step();
    step();
    checks++;
    if (st1 !== 5'b01100 || wd1 !== 32'hEE223344) begin
      errors++;
      $display("FAIL lane_sb_wr got st=%b wdata=%h want 01100 ee223344", st1, wd1);
    end
    repeat (4) step();
    issue(32'h42, 32'h0000BBCC, 2'b01);
    step();
    step();
    checks++;
    if (st1 !== 5'b01100 || wd1 !== 32'hBBCC3344 || a1 !== 32'h40) begin
      errors++;
      $display("FAIL lane_sh_hi got st=%b wdata=%h addr=%h want 01100 bbcc3344 00000040", st1, wd1, a1);
    end
    repeat (4) step();
    issue(32'h41, 32'h0000BBCC, 2'b01);
    checks++;
    if (st1 !== 5'b00111 || st3 !== 5'b00111 || a1 !== 32'h0) begin
      errors++;
      $display("FAIL lane_sh_err got st1=%b st3=%b addr=%h want 00111 00111 0", st1, st3, a1);
    end
    step();
    checks++;
    if (st1 !== 5'b00000) begin
      errors++;
      $display("FAIL lane_err_idle got st=%b want 00000", st1);
    end
    issue(32'h42, 32'h12345678, 2'b00);
    checks++;
    if (st1 !== 5'b00111) begin
      errors++;
      $display("FAIL lane_sw_err got st=%b want 00111", st1);
    end
    step();
`else
    issue(32'h43, 32'h000000EE, 2'b10);
    checks++;
    if (st1 !== 5'b10100 || a1 !== 32'h43) begin
      errors++;
      $display("FAIL nolane_sb_rd got st=%b addr=%h want 10100 00000043", st1, a1);
    end
    step();
    step();
    checks++;
    if (st1 !== 5'b01100 || wd1 !== 32'h112233EE) begin
      errors++;
      $display("FAIL nolane_sb_wr got st=%b wdata=%h want 01100 112233ee", st1, wd1);
    end
    repeat (4) step();
    issue(32'h41, 32'hAAAABBCC, 2'b01);
    checks++;
    if (st1 !== 5'b10100 || a1 !== 32'h41) begin
      errors++;
      $display("FAIL nolane_sh_rd got st=%b addr=%h want 10100 00000041", st1, a1);
    end
    step();
    step();
    checks++;
    if (st1 !== 5'b01100 || wd1 !== 32'h1122BBCC) begin
      errors++;
      $display("FAIL nolane_sh_wr got st=%b wdata=%h want 01100 1122bbcc", st1, wd1);
    end
    repeat (4) step();
`endif
  endtask

  initial begin
    test_reset();
    test_sw();
    test_back_to_back();
    test_sh_lat1();
    test_sb_lat3();
    test_start_in_wait();
    test_reset_mid();
    test_lane();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
